// File: rtl/adc_fft_pkg.sv
// ============================================================================
// adc_fft_pkg
// Shared constants and types for the ADC-to-FFT read path: frame geometry,
// sample/complex word types and the frame-reader state encoding.
// The ADC_OFFSET_BIN_EN macro (used by adc_frame_reader) selects
// offset-binary sample interpretation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_fft_pkg;

  localparam int IN_W       = 12;
  localparam int OUT_W      = 16;
  localparam int FRAME_LOG2 = 10;
  localparam int FRAME_LEN  = 1 << FRAME_LOG2;

  // Frame reader control states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    STREAM    = 2'd2,
    DRAIN     = 2'd3
  } state_e;

  typedef logic [IN_W-1:0] sample_t;

  typedef struct packed {
    logic [OUT_W-1:0] im;
    logic [OUT_W-1:0] re;
  } cplx_t;

endpackage

`default_nettype wire

// File: rtl/adc_skid_buf2.sv
// ============================================================================
// adc_skid_buf2
// Two-entry FIFO for {cplx_t, last} output beats. Entry 0 is always the head,
// so the head word comes straight from a register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_skid_buf2 #(
  parameter int W = 2 * adc_fft_pkg::OUT_W + 1
) (
  input  logic         rd_clk,
  input  logic         rd_rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic [1:0]   r_cnt;

  // Shift-style storage: pops move entry 1 into the head slot
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_cnt == 2'd0)
            r_e0 <= din;
          else if (r_cnt == 2'd1)
            r_e1 <= din;
          if (r_cnt != 2'd2)
            r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt != 2'd0) begin
            r_e0  <= r_e1;
            r_cnt <= r_cnt - 2'd1;
          end
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= din;
          end else if (r_cnt == 2'd1) begin
            r_e0 <= din;
          end else begin
            // Nothing to pop: behaves as a plain push
            r_e0  <= din;
            r_cnt <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_e0;
  assign count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/adc_frame_reader.sv
// ============================================================================
// adc_frame_reader
// Read-side consumer of the ADC sample FIFO. Waits for a full frame in the
// FIFO, drains exactly FRAME_LEN samples, converts each to a signed complex
// word and streams it out on a valid/ready interface with a last marker.
// Build option: define ADC_OFFSET_BIN_EN to treat samples as offset-binary.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_frame_reader #(
  parameter int IN_W       = adc_fft_pkg::IN_W,
  parameter int LVL_W      = 12,
  parameter int OUT_W      = adc_fft_pkg::OUT_W,
  parameter int FRAME_LOG2 = adc_fft_pkg::FRAME_LOG2,
  parameter int FRAME_LEN  = adc_fft_pkg::FRAME_LEN
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               start,
  input  logic               cont,
  output logic               fifo_rd_en,
  input  logic [IN_W-1:0]    fifo_rd_data,
  input  logic               fifo_rd_empty,
  input  logic [LVL_W-1:0]   fifo_rd_water_level,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [2*OUT_W-1:0] m_tdata,
  output logic               m_tlast,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  import adc_fft_pkg::*;

  localparam logic [FRAME_LOG2:0] c_frame_len = (FRAME_LOG2 + 1)'(FRAME_LEN);
  localparam logic [FRAME_LOG2:0] c_one       = (FRAME_LOG2 + 1)'(1);
  localparam logic [LVL_W-1:0]    c_fill_lvl  = LVL_W'(FRAME_LEN);

  state_e              r_state;
  logic [FRAME_LOG2:0] r_reads_left;
  logic [FRAME_LOG2:0] r_beats_left;
  logic                r_inflight;
  logic [15:0]         r_frame_cnt;

  logic                w_pop;
  logic                w_rd_en;
  logic [2:0]          w_occ;
  logic [1:0]          w_buf_cnt;
  logic [IN_W-1:0]     w_sample;
  logic [OUT_W-1:0]    w_real;
  logic [2*OUT_W:0]    w_push_word;
  logic [2*OUT_W:0]    w_head;

  // Occupancy the buffer will have once in-flight data lands and this
  // cycle's pop retires; a new read is only safe if a slot remains.
  assign w_pop   = m_tvalid & m_tready;
  assign w_occ   = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en = (r_state == STREAM) && (r_reads_left != '0) &&
                   !fifo_rd_empty && (w_occ < 3'd2);

  // Sample conversion: optional MSB flip, then sign extension
  always_comb begin
`ifdef ADC_OFFSET_BIN_EN
    w_sample = {~fifo_rd_data[IN_W-1], fifo_rd_data[IN_W-2:0]};
`else
    w_sample = fifo_rd_data;
`endif
    w_real = {{(OUT_W - IN_W){w_sample[IN_W-1]}}, w_sample};
  end

  // A returning read is the frame's last sample once no reads remain
  assign w_push_word = {(r_reads_left == '0), {OUT_W{1'b0}}, w_real};

  // Read-return tracking: FIFO data is valid one cycle after the read
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)
      r_inflight <= 1'b0;
    else
      r_inflight <= w_rd_en;
  end

  // Frame control: state, read/beat budgets and completed-frame count
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state      <= IDLE;
      r_reads_left <= '0;
      r_beats_left <= '0;
      r_frame_cnt  <= 16'd0;
    end else begin
      if (w_rd_en)
        r_reads_left <= r_reads_left - c_one;
      if (w_pop && (r_beats_left != '0))
        r_beats_left <= r_beats_left - c_one;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= WAIT_FILL;
            r_reads_left <= c_frame_len;
            r_beats_left <= c_frame_len;
          end
        end
        WAIT_FILL: begin
          if (fifo_rd_water_level >= c_fill_lvl)
            r_state <= STREAM;
        end
        STREAM: begin
          if ((w_rd_en && (r_reads_left == c_one)) || (r_reads_left == '0))
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pop && m_tlast) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            if (cont) begin
              r_state      <= WAIT_FILL;
              r_reads_left <= c_frame_len;
              r_beats_left <= c_frame_len;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  adc_skid_buf2 #(
    .W (2 * OUT_W + 1)
  ) u_buf (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .push   (r_inflight),
    .din    (w_push_word),
    .pop    (w_pop),
    .dout   (w_head),
    .count  (w_buf_cnt)
  );

  assign fifo_rd_en = w_rd_en;
  assign m_tvalid   = (w_buf_cnt != 2'd0);
  assign m_tdata    = w_head[2*OUT_W-1:0];
  assign m_tlast    = m_tvalid & w_head[2*OUT_W];
  assign busy       = (r_state != IDLE);
  assign frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adc_frame_reader.sv
// ============================================================================
// tb_adc_frame_reader
// Scoreboard bench for adc_frame_reader: a queue-based FIFO model feeds the
// DUT, every written sample enqueues its expected output beat, and a monitor
// compares each accepted beat.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_frame_reader;

  localparam int FLEN = 1024;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        fifo_rd_en;
  logic [11:0] fifo_rd_data = 12'd0;
  logic        fifo_rd_empty = 1'b1;
  logic [11:0] fifo_rd_water_level = 12'd0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        busy;
  logic [15:0] frame_cnt;

  adc_frame_reader dut (
    .rd_clk              (rd_clk),
    .rd_rst              (rd_rst),
    .start               (start),
    .cont                (cont),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (fifo_rd_water_level),
    .m_tvalid            (m_tvalid),
    .m_tready            (m_tready),
    .m_tdata             (m_tdata),
    .m_tlast             (m_tlast),
    .busy                (busy),
    .frame_cnt           (frame_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  int          fifo_q[$];
  exp_t        exp_q[$];
  int          wr_idx = 0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rd_pulses = 0;
  int          beats = 0;
  int          ready_mode = 0;
  int          first_v_cyc = 0;
  int          last_cyc = 0;

  // Reference conversion straight from the numeric meaning of the sample
  function automatic logic [31:0] ref_word(input int s);
    int v;
`ifdef ADC_OFFSET_BIN_EN
    v = s - 2048;
`else
    v = (s >= 2048) ? s - 4096 : s;
`endif
    return {16'h0000, 16'(v)};
  endfunction

  function automatic void update_flags();
    fifo_rd_empty       = (fifo_q.size() == 0);
    fifo_rd_water_level = 12'(fifo_q.size());
  endfunction

  // Writing a sample into the FIFO also records the beat it must become
  task automatic write_sample(input int s);
    exp_t e;
    fifo_q.push_back(s);
    e.d = ref_word(s);
    e.l = ((wr_idx % FLEN) == FLEN - 1);
    exp_q.push_back(e);
    wr_idx++;
    update_flags();
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk);
    end
    #2;
  endtask

  task automatic pulse_start();
    @(posedge rd_clk); #2;
    start = 1'b1;
    @(posedge rd_clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_frame(input int n, input int budget);
    int k;
    k = 0;
    while (frame_cnt != 16'(n) && k < budget) begin
      @(posedge rd_clk);
      k++;
    end
    #2;
    check("frame_wait", int'(frame_cnt), n);
  endtask

  always @(posedge rd_clk) cyc <= cyc + 1;

  // FIFO model: a read seen in a cycle returns data just after that edge
  initial begin
    logic en_s;
    forever begin
      @(negedge rd_clk);
      en_s = fifo_rd_en && !rd_rst;
      @(posedge rd_clk);
      #1;
      if (en_s && fifo_q.size() > 0)
        fifo_rd_data = 12'(fifo_q.pop_front());
      update_flags();
    end
  end

  // Downstream ready: always-on, or alternating then random stalls
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge rd_clk); #1;
      if (ready_mode == 0) begin
        m_tready = 1'b1;
        k = 0;
      end else begin
        m_tready = (k < 64) ? ((k % 2) == 0) : ($urandom_range(0, 3) != 0);
        k++;
      end
    end
  end

  // Monitor: scoreboard on accepted beats plus protocol checks
  initial begin
    exp_t        e;
    logic        armed;
    logic        want_lat;
    int          rd_cyc;
    logic        hold_v;
    logic [31:0] hold_d;
    logic        hold_l;
    armed = 1'b1; want_lat = 1'b0; rd_cyc = 0; hold_v = 1'b0;
    hold_d = 32'd0; hold_l = 1'b0;
    forever begin
      @(negedge rd_clk);
      if (rd_rst) begin
        armed = 1'b1; want_lat = 1'b0; hold_v = 1'b0; beats = 0;
      end else begin
        if (fifo_rd_en) begin
          rd_pulses++;
          check("rd_while_empty", int'(fifo_rd_empty), 0);
          if (armed) begin
            check("level_at_first_read", int'(fifo_rd_water_level >= 12'(FLEN)), 1);
            armed = 1'b0; want_lat = 1'b1; rd_cyc = cyc;
          end
        end
        if (want_lat && m_tvalid) begin
          check("first_valid_latency", cyc - rd_cyc, 2);
          first_v_cyc = cyc;
          want_lat = 1'b0;
        end
        if (hold_v) begin
          check("stall_hold_valid", int'(m_tvalid), 1);
          check("stall_hold_data", int'(m_tdata), int'(hold_d));
          check("stall_hold_last", int'(m_tlast), int'(hold_l));
        end
        hold_v = m_tvalid & !m_tready;
        hold_d = m_tdata;
        hold_l = m_tlast;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL beat_unexpected: got data=%h last=%0d expected no beat", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", int'(m_tdata), int'(e.d));
            check("beat_last", int'(m_tlast), int'(e.l));
          end
          beats++;
          if (m_tlast) begin
            armed = 1'b1;
            beats = 0;
            last_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    int k;

    // Reset with a full frame already waiting in the FIFO
    for (int i = 0; i < FLEN; i++) write_sample(i);
    tick(3);
    check("rst_tvalid", int'(m_tvalid), 0);
    check("rst_tdata", int'(m_tdata), 0);
    check("rst_tlast", int'(m_tlast), 0);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    rd_rst = 1'b0;
    tick(6);
    check("idle_no_reads", rd_pulses, 0);
    check("idle_busy", int'(busy), 0);
    check("idle_tvalid", int'(m_tvalid), 0);

    // Single frame with ready held high: contiguous beats
    rd_pulses = 0;
    pulse_start();
    wait_frame(1, 5000);
    tick(2);
    check("f1_reads", rd_pulses, FLEN);
    check("f1_busy", int'(busy), 0);
    check("f1_span", last_cyc - first_v_cyc, FLEN - 1);
    check("f1_exp_left", exp_q.size(), 0);

    // Same samples under backpressure; a stray start mid-frame is ignored
    ready_mode = 1;
    for (int i = 0; i < FLEN; i++) write_sample(i);
    rd_pulses = 0;
    pulse_start();
    tick(100);
    pulse_start();
    wait_frame(2, 10000);
    tick(4);
    check("f2_reads", rd_pulses, FLEN);
    check("f2_busy", int'(busy), 0);
    check("f2_exp_left", exp_q.size(), 0);
    ready_mode = 0;

    // Continuous mode: second burst trickles in and crosses the level late
    cont = 1'b1;
    rd_pulses = 0;
    for (int i = 0; i < FLEN; i++) write_sample(int'($urandom_range(0, 4095)));
    pulse_start();
    fork
      begin
        for (int i = 0; i < FLEN; i++) begin
          write_sample(int'($urandom_range(0, 4095)));
          tick(4);
        end
      end
    join_none
    wait_frame(3, 5000);
    check("cont_wait_busy", int'(busy), 1);
    check("cont_wait_no_read", int'(fifo_rd_en), 0);
    check("cont_wait_level_low", int'(fifo_rd_water_level < 12'(FLEN)), 1);
    cont = 1'b0;
    wait_frame(4, 12000);
    tick(4);
    check("cont_reads", rd_pulses, 2 * FLEN);
    check("cont_busy", int'(busy), 0);
    check("cont_exp_left", exp_q.size(), 0);

    // Reset mid-frame, then a clean frame after refill
    for (int i = 0; i < FLEN; i++) write_sample(int'($urandom_range(0, 4095)));
    pulse_start();
    k = 0;
    while (beats < 500 && k < 5000) begin
      @(posedge rd_clk);
      k++;
    end
    #2;
    check("abort_reached_500", int'(beats >= 500), 1);
    rd_rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    wr_idx = 0;
    update_flags();
    #1;
    check("abort_tvalid", int'(m_tvalid), 0);
    check("abort_tlast", int'(m_tlast), 0);
    check("abort_rd_en", int'(fifo_rd_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_frame_cnt", int'(frame_cnt), 0);
    tick(2);
    rd_rst = 1'b0;
    tick(2);
    for (int i = 0; i < FLEN; i++) write_sample(int'($urandom_range(0, 4095)));
    rd_pulses = 0;
    pulse_start();
    wait_frame(1, 5000);
    tick(2);
    check("post_abort_reads", rd_pulses, FLEN);
    check("post_abort_exp_left", exp_q.size(), 0);

    // Conversion corner codes at the head of a frame
    write_sample(12'h800);
    write_sample(12'h000);
    write_sample(12'hFFF);
    for (int i = 3; i < FLEN; i++) write_sample(int'($urandom_range(0, 4095)));
    pulse_start();
    wait_frame(2, 5000);
    tick(2);
    check("conv_exp_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/adc_frame_reader.md
Name: adc_frame_reader

Overview:
Read-side consumer of the ADC sample FIFO, running in the rd_clk domain.
- Waits until the FIFO holds one complete frame of samples.
- Drains exactly FRAME_LEN samples as one contiguous frame.
- Converts each 12-bit sample to a signed complex word and presents it on a valid/ready stream with a last-beat marker, feeding the FFT input stage.
- A 2-entry output buffer absorbs the FIFO's 1-cycle read latency and downstream backpressure.

Parameters:
- IN_W, 12: ADC sample width from the FIFO.
- LVL_W, 12: width of the FIFO read water level (read depth width + 1).
- OUT_W, 16: width of each real/imag component on the output.
- FRAME_LOG2, 10: log2 of the frame length.
- FRAME_LEN, 1024: samples per frame; equals 2**FRAME_LOG2 and must be ≤ 2**(LVL_W-1).

Ports:
- rd_clk  in  1: clock; same clock as the FIFO read port.
- rd_rst  in  1: reset, asynchronous, active-high.
- start  in  1: single-cycle pulse that arms frame capture; honoured only in IDLE.
- cont  in  1: continuous mode; level sampled at frame end.
- fifo_rd_en  out  1: FIFO read enable.
- fifo_rd_data  in  IN_W: FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_rd_empty  in  1: FIFO empty flag.
- fifo_rd_water_level  in  LVL_W: FIFO read-side fill level.
- m_tvalid  out  1: output beat valid.
- m_tready  in  1: output beat accepted.
- m_tdata  out  2*OUT_W: {imag, real}; imag is always 0.
- m_tlast  out  1: marks the last beat of a frame.
- busy  out  1: high whenever state != IDLE.
- frame_cnt  out  16: completed frames; wraps at 0xFFFF→0.

Behaviour:
- Reset: all outputs 0. State=IDLE, reads_left=0, inflight=0, buffer empty, frame_cnt=0.
- States and transitions:
  - IDLE: start=1 → WAIT_FILL.
  - WAIT_FILL: fifo_rd_water_level ≥ FRAME_LEN → STREAM. On entry reads_left=FRAME_LEN and beats_left=FRAME_LEN.
  - STREAM: reads_left reaching 0 → DRAIN.
  - DRAIN: the beat with m_tlast is accepted → WAIT_FILL if cont=1, else IDLE. frame_cnt increments in the same cycle.
- Read issue (combinational):
  - fifo_rd_en = (state==STREAM) & (reads_left≠0) & !fifo_rd_empty & (buf_cnt + inflight − pop < 2).
  - pop = m_tvalid & m_tready.
  - fifo_rd_en never asserts while the FIFO is empty; each assertion is exactly one read and decrements reads_left.
- Read return:
  - inflight <= fifo_rd_en.
  - When inflight=1, the converted fifo_rd_data is pushed to the buffer tail that cycle.
  - Push and pop in the same cycle leave buf_cnt unchanged.
- Output stream:
  - m_tvalid = (buf_cnt≠0); m_tdata and m_tlast are driven from the registered buffer head.
  - Throughput is 1 beat/cycle while m_tready=1.
  - First m_tvalid occurs 2 cycles after the first fifo_rd_en.
  - m_tdata/m_tlast are held stable while m_tvalid=1 and m_tready=0.
  - m_tlast=1 only on the beat where beats_left==1; beats_left decrements on pop.
- Conversion (default, macro undefined): real = sign-extension of the IN_W sample to OUT_W; imag = 0.
- Boundary conditions:
  - start while not IDLE: ignored.
  - cont falling mid-frame: current frame completes, then IDLE.
  - fifo_rd_empty mid-frame: reads stall, no bubble lost and no duplicate issued; frame resumes when data returns.
  - rd_rst mid-frame: immediate abort, buffer flushed, partial frame discarded without m_tlast.
  - No sample beyond FRAME_LEN per frame is ever read.

Optional Feature:
ADC_OFFSET_BIN_EN
- Defined: sample is treated as offset-binary. Invert the MSB, then sign-extend: 12'h800→16'h0000, 12'h000→16'hF800, 12'hFFF→16'h07FF.
- Undefined: two's-complement sign extension only: 12'h800→16'hF800.

Decomposition:
- Shared package adc_fft_pkg:
  - FRAME_LOG2/FRAME_LEN, IN_W, OUT_W constants.
  - State enum {IDLE, WAIT_FILL, STREAM, DRAIN}.
  - sample_t and cplx_t typedefs.
- One natural sub-module: adc_skid_buf2, a 2-entry FIFO holding {cplx_t, last} with push/pop/count.

Test Plan:
1. Reset with m_tready=1, FIFO pre-filled with 1024 words → all outputs 0 and fifo_rd_en=0 until start.
2. Samples 0..1023 pre-filled, start pulse, m_tready=1 → 1024 contiguous beats, real=0..1023 in order, m_tlast only on beat 1024, frame_cnt=1, return to IDLE.
3. m_tready toggling 1,0,1,0 plus random stalls → output sequence identical to test 2, buffer never exceeds 2, no extra FIFO reads (exactly 1024 fifo_rd_en pulses).
4. cont=1 with 2048 samples supplied in two bursts; second burst's level crosses 1024 late → two frames, frame_cnt=2, WAIT_FILL held until level ≥ 1024.
5. Pulse rd_rst after beat 500 → outputs 0 next cycle; a fresh start after refill yields a clean full frame.
6. Inputs 12'h800, 12'h000, 12'hFFF, macro on/off → real values as listed under Optional Feature, imag=0.
